// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock sequencing controller.
package lock_pkg;

   typedef enum logic [2:0] {
      ENTRY   = 3'd0,
      CLOSED  = 3'd1,
      OPEN    = 3'd2,
      PROG    = 3'd3,
      LOCKOUT = 3'd4
   } state_e;

   localparam logic [2:0] DISP_DIGIT  = 3'd0;
   localparam logic [2:0] DISP_CLOSED = 3'd1;
   localparam logic [2:0] DISP_OPEN   = 3'd2;
   localparam logic [2:0] DISP_LOCKED = 3'd3;
   localparam logic [2:0] DISP_PROG   = 3'd4;

   typedef logic [3:0] bcd_t;

   // Digit 0 of the code is the most significant nibble.
   localparam logic [23:0] DEFAULT_CODE = 24'h722297;

   function automatic logic isLegal(input bcd_t d);
      return d <= 4'd9;
   endfunction

   function automatic logic [2:0] dispFor(input state_e s);
      logic [2:0] m;
      case (s)
         CLOSED:  m = DISP_CLOSED;
         OPEN:    m = DISP_OPEN;
         PROG:    m = DISP_PROG;
         LOCKOUT: m = DISP_LOCKED;
         default: m = DISP_DIGIT;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lock_code_store.sv
// Active code and programming shadow; commit copies the shadow, including any
// nibble written in the same cycle, into the active code in one edge.
module lock_code_store
   import lock_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter logic [4*NUM_DIGITS-1:0] RESET_CODE = lock_pkg::DEFAULT_CODE,
   localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrEn_i,
   input  logic [POS_W-1:0] wrPos_i,
   input  bcd_t             wrData_i,
   input  logic             commit_i,
   input  logic [POS_W-1:0] rdPos_i,
   output bcd_t             codeDigit_o
);

   logic [4*NUM_DIGITS-1:0] code_q;
   logic [4*NUM_DIGITS-1:0] shadow_q;
   logic [4*NUM_DIGITS-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wrEn_i && (wrPos_i == POS_W'(i))) begin
            shadow_d[(NUM_DIGITS-1-i)*4 +: 4] = wrData_i;
         end
      end
   end

   always_comb begin
      codeDigit_o = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (rdPos_i == POS_W'(i)) begin
            codeDigit_o = code_q[(NUM_DIGITS-1-i)*4 +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         code_q   <= RESET_CODE;
         shadow_q <= RESET_CODE;
      end else begin
         shadow_q <= shadow_d;
         if (commit_i) begin
            code_q <= shadow_d;
         end
      end
   end

endmodule

// File: rtl/lock_seq_ctrl.sv
// Sequencing controller: digit entry and compare, failure counting, timed
// lockout and code re-programming, with fully registered outputs.
module lock_seq_ctrl
   import lock_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE,
   localparam int POS_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int FAIL_W  = $clog2(MAX_FAILS + 1),
   localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              digit_valid,
   input  logic [3:0]        digit,
   input  logic              clear,
   input  logic              prog_req,
   output logic [2:0]        disp_mode,
   output logic              unlocked,
   output logic              bad_digit,
   output logic [POS_W-1:0]  pos,
   output logic [FAIL_W-1:0] fail_cnt
);

   localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 1);

   state_e              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                mismatch_q, mismatch_d;
   logic [FAIL_W-1:0]   failCnt_q, failCnt_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [2:0]          dispMode_q;
   logic                unlocked_q;
   logic                badDigit_q, badDigit_d;

   logic wrEn;
   logic commit;
   logic legal;
   logic miss;
   bcd_t curDigit;

   lock_code_store #(
      .NUM_DIGITS (NUM_DIGITS),
      .RESET_CODE (DEFAULT_CODE)
   ) uCodeStore (
      .clk         (clk),
      .reset       (reset),
      .wrEn_i      (wrEn),
      .wrPos_i     (pos_q),
      .wrData_i    (digit),
      .commit_i    (commit),
      .rdPos_i     (pos_q),
      .codeDigit_o (curDigit)
   );

   assign legal = isLegal(digit);
   assign miss  = mismatch_q | ~legal | (digit != curDigit);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      mismatch_d = mismatch_q;
      failCnt_d  = failCnt_q;
      timer_d    = timer_q;
      badDigit_d = 1'b0;
      wrEn       = 1'b0;
      commit     = 1'b0;
      case (state_q)
         ENTRY: begin
            if (clear) begin
               pos_d      = '0;
               mismatch_d = 1'b0;
            end else if (digit_valid) begin
               badDigit_d = ~legal;
               if (pos_q == LAST_POS) begin
                  pos_d      = '0;
                  mismatch_d = 1'b0;
                  if (!miss) begin
                     state_d   = OPEN;
                     failCnt_d = '0;
                  end else if (int'(failCnt_q) + 1 < MAX_FAILS) begin
                     state_d   = CLOSED;
                     failCnt_d = failCnt_q + FAIL_W'(1);
                  end else begin
                     state_d   = LOCKOUT;
                     timer_d   = TIMER_W'(LOCKOUT_CYCLES - 1);
                     failCnt_d = FAIL_W'(MAX_FAILS);
                  end
               end else begin
                  pos_d      = pos_q + POS_W'(1);
                  mismatch_d = miss;
               end
            end
         end
         CLOSED: begin
            if (clear) begin
               state_d = ENTRY;
               pos_d   = '0;
            end
         end
         OPEN: begin
            if (clear) begin
               state_d = ENTRY;
               pos_d   = '0;
            end else if (prog_req) begin
               state_d = PROG;
               pos_d   = '0;
            end
         end
         PROG: begin
            // Abort keeps the active code; partial shadow contents are overwritten next time.
            if (clear) begin
               state_d = OPEN;
               pos_d   = '0;
            end else if (digit_valid) begin
               if (!legal) begin
                  badDigit_d = 1'b1;
               end else begin
                  wrEn = 1'b1;
                  if (pos_q == LAST_POS) begin
                     commit  = 1'b1;
                     state_d = OPEN;
                     pos_d   = '0;
                  end else begin
                     pos_d = pos_q + POS_W'(1);
                  end
               end
            end
         end
         LOCKOUT: begin
            if (timer_q == '0) begin
               state_d   = ENTRY;
               failCnt_d = '0;
               pos_d     = '0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d    = ENTRY;
            pos_d      = '0;
            mismatch_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ENTRY;
         pos_q      <= '0;
         mismatch_q <= 1'b0;
         failCnt_q  <= '0;
         timer_q    <= '0;
         dispMode_q <= DISP_DIGIT;
         unlocked_q <= 1'b0;
         badDigit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         mismatch_q <= mismatch_d;
         failCnt_q  <= failCnt_d;
         timer_q    <= timer_d;
         dispMode_q <= dispFor(state_d);
         unlocked_q <= (state_d == OPEN) || (state_d == PROG);
         badDigit_q <= badDigit_d;
      end
   end

   assign disp_mode = dispMode_q;
   assign unlocked  = unlocked_q;
   assign bad_digit = badDigit_q;
   assign pos       = pos_q;
   assign fail_cnt  = failCnt_q;

endmodule
